// File: rtl/data_bus_if.sv
// data_bus_if: MEM-stage load/store unit driving a single-beat, big-endian
// classic bus master (cyc/stb/we/adr/sel/dat with ack/err).
// Optional feature macro: DBUS_TIMEOUT_EN adds a 4-bit bus timeout counter
// (16 BUS cycles without ack/err ends the access with an error).
//
// Handshake: req_i is a level held by the pipeline until done_o. One access
// is in flight at a time. The bus cycle is open while state is BUS
// (cyc=stb=1); it ends at the first rising edge where bus_ack_i or
// bus_err_i is high. ack/err seen outside BUS are ignored.
module data_bus_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d;
  logic        flush_q, flush_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef DBUS_TIMEOUT_EN
  logic [3:0]  cnt_q, cnt_d;
`endif

  logic        aligned;
  logic [3:0]  sel_w;
  logic [31:0] dat_w;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        flush_seen;

  // Decode alignment, big-endian byte lanes and replicated store data
  always_comb begin
    aligned = 1'b1;
    sel_w   = 4'b1111;
    dat_w   = wdata_i;
    case (size_i)
      2'b00: begin
        sel_w = 4'b1000 >> addr_i[1:0];
        dat_w = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        aligned = ~addr_i[0];
        sel_w   = addr_i[1] ? 4'b0011 : 4'b1100;
        dat_w   = {2{wdata_i[15:0]}};
      end
      default: begin
        aligned = (addr_i[1:0] == 2'b00);
      end
    endcase
  end

  // Extract the addressed lane(s) of bus_dat_i and extend to 32 bits
  always_comb begin
    ld_byte = 8'h00;
    ld_half = lane_q[1] ? bus_dat_i[15:0] : bus_dat_i[31:16];
    case (lane_q)
      2'd0:    ld_byte = bus_dat_i[31:24];
      2'd1:    ld_byte = bus_dat_i[23:16];
      2'd2:    ld_byte = bus_dat_i[15:8];
      default: ld_byte = bus_dat_i[7:0];
    endcase
    case (size_q)
      2'b00:   ld_data = {{24{sext_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sext_q & ld_half[15]}}, ld_half};
      default: ld_data = bus_dat_i;
    endcase
  end

  assign flush_seen = flush_q | flush_i;

  // Next-state logic: accept in IDLE, wait for ack/err in BUS, pulse in DONE
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    size_d  = size_q;
    sext_d  = sext_q;
    lane_d  = lane_q;
    err_d   = err_q;
    flush_d = flush_q;
    rdata_d = rdata_q;
`ifdef DBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i && !flush_i) begin
          if (aligned) begin
            state_d = S_BUS;
            we_d    = we_i;
            adr_d   = {addr_i[31:2], 2'b00};
            sel_d   = sel_w;
            dat_d   = dat_w;
            size_d  = size_i;
            sext_d  = sext_i;
            lane_d  = addr_i[1:0];
            err_d   = 1'b0;
            flush_d = 1'b0;
`ifdef DBUS_TIMEOUT_EN
            cnt_d   = 4'd0;
`endif
          end else begin
            // Misaligned: no bus cycle, report an error straight away
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end
        end
      end
      S_BUS: begin
        flush_d = flush_seen;
`ifdef DBUS_TIMEOUT_EN
        cnt_d   = cnt_q + 4'd1;
`endif
        if (bus_ack_i || bus_err_i) begin
          // A flushed access still finishes on the bus, but its result is dropped
          state_d = flush_seen ? S_IDLE : S_DONE;
          if (!flush_seen) begin
            err_d   = bus_err_i;
            rdata_d = (bus_err_i || we_q) ? 32'h0 : ld_data;
          end
        end
`ifdef DBUS_TIMEOUT_EN
        else if (cnt_q == 4'd15) begin
          state_d = flush_seen ? S_IDLE : S_DONE;
          if (!flush_seen) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and request registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      sel_q   <= 4'h0;
      dat_q   <= 32'h0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      lane_q  <= 2'b00;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
      rdata_q <= 32'h0;
`ifdef DBUS_TIMEOUT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
      flush_q <= flush_d;
      rdata_q <= rdata_d;
`ifdef DBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // cyc/stb follow the state so reset drops them immediately
  assign bus_cyc_o = (state_q == S_BUS);
  assign bus_stb_o = (state_q == S_BUS);
  assign bus_we_o  = we_q;
  assign bus_adr_o = adr_q;
  assign bus_sel_o = sel_q;
  assign bus_dat_o = dat_q;
  assign rdata_o   = rdata_q;
  assign done_o    = (state_q == S_DONE);
  assign err_o     = (state_q == S_DONE) && err_q;
  assign stall_o   = ((state_q == S_IDLE) && req_i && !flush_i) || (state_q == S_BUS);
  assign state_o   = state_q;

endmodule

// File: tb/tb_data_bus_if.sv
// Directed bench for data_bus_if: big-endian lane selection, load extension,
// store replication, misalignment, bus error, flush, reset and timeout.
module tb_data_bus_if;

  logic        clk;
  logic        rst;
  logic        req_i, we_i, sext_i, flush_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic [31:0] rdata_o;
  logic        stall_o, done_o, err_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i, bus_err_i;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Results captured by run_access
  logic        r_cyc, r_we, r_done, r_err, r_stall0, r_stall, r_done2, r_stable, r_timeout;
  logic [3:0]  r_sel;
  logic [31:0] r_adr, r_dat, r_rdata;
  logic [1:0]  r_state;
  int          r_lat;

  data_bus_if dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .size_i(size_i),
    .sext_i(sext_i), .wdata_i(wdata_i), .flush_i(flush_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .done_o(done_o), .err_o(err_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
    .state_o(state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request starting at a falling edge and plays the bus slave:
  // ack (or err) after wait_n BUS cycles, optional flush pulse in the first BUS cycle.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic sext, input logic [31:0] wdata, input int wait_n,
                            input logic [31:0] bdat, input logic use_err, input logic flush_mid);
    int n;
    int bus_n;
    r_cyc = 0; r_we = 0; r_sel = 0; r_adr = 0; r_dat = 0; r_stable = 1; r_timeout = 0;
    req_i = 1; we_i = we; addr_i = addr; size_i = size; sext_i = sext; wdata_i = wdata;
    #1 r_stall0 = stall_o;
    n = 0;
    bus_n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      bus_ack_i = 0; bus_err_i = 0; flush_i = 0;
      if (done_o) break;
      if (bus_cyc_o) begin
        if (bus_n == 0) begin
          r_sel = bus_sel_o; r_adr = bus_adr_o; r_dat = bus_dat_o; r_we = bus_we_o;
        end else if (bus_sel_o !== r_sel || bus_adr_o !== r_adr || bus_dat_o !== r_dat ||
                     bus_we_o !== r_we || bus_stb_o !== 1'b1) begin
          r_stable = 0;
        end
        r_cyc = 1;
        bus_n++;
        if (flush_mid && bus_n == 1) flush_i = 1;
        if (bus_n == wait_n + 1) begin
          bus_dat_i = bdat;
          if (use_err) bus_err_i = 1;
          else bus_ack_i = 1;
        end
      end else if (r_cyc) begin
        break;
      end
      if (n > 60) begin
        r_timeout = 1;
        break;
      end
    end
    r_lat = n; r_done = done_o; r_err = err_o; r_rdata = rdata_o; r_stall = stall_o; r_state = state_o;
    req_i = 0;
    @(negedge clk);
    r_done2 = done_o;
  endtask

  initial begin
    int bus_cycles;
    logic done_any;
    req_i = 0; we_i = 0; addr_i = 0; size_i = 0; sext_i = 0; wdata_i = 0; flush_i = 0;
    bus_dat_i = 0; bus_ack_i = 0; bus_err_i = 0;

    // Reset state (asynchronous, before any clock edge)
    rst = 1;
    #3;
    check("rst_cyc",   {31'b0, bus_cyc_o}, 32'd0);
    check("rst_stb",   {31'b0, bus_stb_o}, 32'd0);
    check("rst_we",    {31'b0, bus_we_o},  32'd0);
    check("rst_adr",   bus_adr_o,          32'd0);
    check("rst_sel",   {28'b0, bus_sel_o}, 32'd0);
    check("rst_dat",   bus_dat_o,          32'd0);
    check("rst_rdata", rdata_o,            32'd0);
    check("rst_done",  {30'b0, done_o, err_o}, 32'd0);
    check("rst_state", {30'b0, state_o},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Load word 0x100, two wait cycles
    run_access(0, 32'h100, 2'b10, 0, 0, 2, 32'h12345678, 0, 0);
    check("lw_stall_req", {31'b0, r_stall0}, 32'd1);
    check("lw_sel",    {28'b0, r_sel}, 32'hF);
    check("lw_adr",    r_adr, 32'h100);
    check("lw_we",     {31'b0, r_we}, 32'd0);
    check("lw_stable", {31'b0, r_stable}, 32'd1);
    check("lw_done",   {30'b0, r_done, r_err}, 32'b10);
    check("lw_rdata",  r_rdata, 32'h12345678);
    check("lw_lat",    r_lat, 32'd4);
    check("lw_stall_done", {31'b0, r_stall}, 32'd0);
    check("lw_done_width", {31'b0, r_done2}, 32'd0);
    check("lw_timeout", {31'b0, r_timeout}, 32'd0);

    // Load byte 0x103, sign and zero extended
    run_access(0, 32'h103, 2'b00, 1, 0, 1, 32'h000000F0, 0, 0);
    check("lb_sel",   {28'b0, r_sel}, 32'h1);
    check("lb_adr",   r_adr, 32'h100);
    check("lb_sext",  r_rdata, 32'hFFFFFFF0);
    run_access(0, 32'h103, 2'b00, 0, 0, 1, 32'h000000F0, 0, 0);
    check("lbu_zext", r_rdata, 32'h000000F0);

    // Load half, minimum latency and upper half
    run_access(0, 32'h202, 2'b01, 1, 0, 0, 32'h12348001, 0, 0);
    check("lh_sel",  {28'b0, r_sel}, 32'h3);
    check("lh_rdata", r_rdata, 32'hFFFF8001);
    check("lh_lat",  r_lat, 32'd2);
    run_access(0, 32'h200, 2'b01, 0, 0, 1, 32'hBEEF0000, 0, 0);
    check("lhu_sel",  {28'b0, r_sel}, 32'hC);
    check("lhu_rdata", r_rdata, 32'h0000BEEF);

    // Store half 0x202: replicated data, store clears rdata
    run_access(1, 32'h202, 2'b01, 0, 32'h0000ABCD, 1, 32'hFFFFFFFF, 0, 0);
    check("sh_adr",   r_adr, 32'h200);
    check("sh_sel",   {28'b0, r_sel}, 32'h3);
    check("sh_dat",   r_dat, 32'hABCDABCD);
    check("sh_we",    {31'b0, r_we}, 32'd1);
    check("sh_rdata", r_rdata, 32'h0);
    check("sh_done",  {30'b0, r_done, r_err}, 32'b10);

    // Store byte 0x101
    run_access(1, 32'h101, 2'b00, 0, 32'h1234565A, 0, 0, 0, 0);
    check("sb_sel", {28'b0, r_sel}, 32'h4);
    check("sb_dat", r_dat, 32'h5A5A5A5A);

    // Reserved size behaves as word
    run_access(0, 32'h300, 2'b11, 1, 0, 0, 32'hCAFEF00D, 0, 0);
    check("lres_sel",   {28'b0, r_sel}, 32'hF);
    check("lres_rdata", r_rdata, 32'hCAFEF00D);

    // Bus error on a load
    run_access(0, 32'h104, 2'b10, 0, 0, 1, 32'h55555555, 1, 0);
    check("berr_done",  {30'b0, r_done, r_err}, 32'b11);
    check("berr_rdata", r_rdata, 32'h0);
    check("berr_width", {31'b0, r_done2}, 32'd0);

    // Misaligned word load: no bus cycle, immediate error
    run_access(0, 32'h101, 2'b10, 0, 0, 0, 0, 0, 0);
    check("mis_cyc",   {31'b0, r_cyc}, 32'd0);
    check("mis_done",  {30'b0, r_done, r_err}, 32'b11);
    check("mis_lat",   r_lat, 32'd1);
    check("mis_stall", {31'b0, r_stall}, 32'd0);
    check("mis_width", {31'b0, r_done2}, 32'd0);
    run_access(1, 32'h203, 2'b01, 0, 32'h1111, 0, 0, 0, 0);
    check("mis_sh",    {29'b0, r_cyc, r_done, r_err}, 32'b011);

    // Flush mid-BUS: cycle completes, no done
    run_access(0, 32'h108, 2'b10, 0, 0, 2, 32'h87654321, 0, 1);
    check("fl_cyc",   {31'b0, r_cyc}, 32'd1);
    check("fl_done",  {31'b0, r_done}, 32'd0);
    check("fl_state", {30'b0, r_state}, 32'd0);
    check("fl_after", {31'b0, r_done2}, 32'd0);

    // Flush in IDLE: no access started
    req_i = 1; flush_i = 1; addr_i = 32'h400; size_i = 2'b10; we_i = 0;
    #1 check("fli_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    check("fli_cyc", {29'b0, bus_cyc_o, state_o}, 32'd0);
    req_i = 0; flush_i = 0;

    // ack/err outside BUS ignored
    bus_ack_i = 1; bus_err_i = 1;
    @(negedge clk);
    bus_ack_i = 0; bus_err_i = 0;
    check("idle_ack", {28'b0, done_o, err_o, state_o}, 32'd0);

    // Reset mid-BUS drops cyc immediately, no done afterwards
    req_i = 1; we_i = 0; addr_i = 32'h400; size_i = 2'b10;
    @(negedge clk);
    check("rb_cyc_before", {31'b0, bus_cyc_o}, 32'd1);
    #2 rst = 1;
    #1 check("rb_cyc_after", {30'b0, bus_cyc_o, bus_stb_o}, 32'd0);
    req_i = 0;
    @(negedge clk);
    rst = 0;
    done_any = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done_any = done_any | done_o | bus_cyc_o;
    end
    check("rb_no_done", {31'b0, done_any}, 32'd0);

    // First access accepted at the first edge after reset release
    rst = 1;
    @(negedge clk);
    rst = 0;
    run_access(0, 32'h100, 2'b00, 1, 0, 0, 32'h7F000000, 0, 0);
    check("first_lat",   r_lat, 32'd2);
    check("first_rdata", r_rdata, 32'h0000007F);

    // No ack: timeout or indefinite wait
    req_i = 1; we_i = 0; addr_i = 32'h500; size_i = 2'b10;
    bus_cycles = 0;
`ifdef DBUS_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) break;
      if (bus_cyc_o) bus_cycles++;
    end
    check("to_cycles", bus_cycles, 32'd16);
    check("to_done",   {29'b0, bus_cyc_o, done_o, err_o}, 32'b011);
    req_i = 0;
    @(negedge clk);
`else
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_cyc_o) bus_cycles++;
    end
    check("nto_cycles", bus_cycles, 32'd30);
    check("nto_stall",  {30'b0, stall_o, done_o}, 32'b10);
    bus_ack_i = 1; bus_dat_i = 32'h0BADF00D;
    @(negedge clk);
    bus_ack_i = 0;
    check("nto_done",  {30'b0, done_o, err_o}, 32'b10);
    check("nto_rdata", rdata_o, 32'h0BADF00D);
    req_i = 0;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_if.md
DATA_BUS_IF -- requirements
Module: data_bus_if

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high (1'b1 = reset asserted).
REQ-003 SHALL have req_i, input, 1: MEM-stage load/store request, level, held until done_o.
REQ-004 SHALL have we_i, input, 1: 1 = store, 0 = load.
REQ-005 SHALL have addr_i, input, 32: byte address.
REQ-006 SHALL have size_i, input, 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-007 SHALL have sext_i, input, 1: sign-extend load result (byte/half only).
REQ-008 SHALL have wdata_i, input, 32: store data, right-justified.
REQ-009 SHALL have flush_i, input, 1: pipeline flush, discard current access result.
REQ-010 SHALL have rdata_o, output, 32: aligned, extended load data; stall_o, output, 1: hold pipeline; done_o, output, 1: one-cycle completion pulse; err_o, output, 1: one-cycle error pulse, coincident with done_o.
REQ-011 SHALL have bus master ports: bus_cyc_o, bus_stb_o, bus_we_o (1 each), bus_adr_o (32, word-aligned, [1:0]=00), bus_sel_o (4), bus_dat_o (32), outputs; bus_dat_i (32), bus_ack_i (1), bus_err_i (1), inputs.

Function
REQ-012 SHALL implement states IDLE, BUS, DONE.
REQ-013 IDLE: req_i=1, flush_i=0, access aligned -> latch request, assert bus_cyc_o/bus_stb_o from next cycle, go BUS.
REQ-014 Alignment: half needs addr_i[0]=0, word needs addr_i[1:0]=00; misaligned -> no bus cycle, go DONE with err flagged.
REQ-015 Byte lanes big-endian: byte sel = 4'b1000>>addr[1:0]; half sel = 1100 (addr[1]=0) or 0011; word sel = 1111.
REQ-016 bus_dat_o SHALL replicate store data: byte on all four lanes, half on both halves, word as-is.
REQ-017 BUS: hold cyc/stb/we/adr/sel/dat stable until bus_ack_i or bus_err_i; on either, deassert cyc/stb at that edge, go DONE.
REQ-018 On ack of a load, capture selected lane(s) of bus_dat_i into rdata_o, zero- or sign-extended per sext_i; stores leave rdata_o at 0.
REQ-019 DONE: done_o=1 and (if flagged) err_o=1 for exactly one cycle; next state IDLE; req_i ignored in DONE.
REQ-020 stall_o SHALL be combinational: 1 when (IDLE and req_i and not flush_i) or BUS; 0 in DONE.
REQ-021 Latency: req at edge N, ack seen at edge N+k (k>=1) -> done_o high during cycle after edge N+k; minimum 3 cycles req-to-done inclusive.
REQ-022 bus_err_i during BUS SHALL set err_o with done_o; rdata_o = 0.
REQ-023 flush_i in IDLE: no access started. flush_i in BUS: bus cycle completes normally, result discarded, done_o/err_o suppressed, return IDLE. Flush recorded if seen in any BUS cycle.
REQ-024 bus_ack_i/bus_err_i outside BUS SHALL be ignored.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE; rdata_o=0, done_o=0, err_o=0, bus_cyc_o=0, bus_stb_o=0, bus_we_o=0, bus_adr_o=0, bus_sel_o=0, bus_dat_o=0, timeout counter 0.
REQ-026 Reset mid-BUS SHALL drop cyc/stb immediately; no done_o after release.
REQ-027 First access SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-028 Macro DBUS_TIMEOUT_EN defined: 4-bit counter cleared on entry to BUS, increments each BUS cycle; when it reaches 15 without ack/err, drop cyc/stb, go DONE with err_o=1 (16 BUS cycles total).
REQ-029 DBUS_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for ack/err.

Verification
REQ-030 Load word addr 0x100, bus_dat_i=0x12345678, ack after 2 wait cycles -> bus_sel_o=1111, rdata_o=0x12345678, done_o one cycle, err_o=0.
REQ-031 Load byte addr 0x103, sext_i=1, bus_dat_i=0x000000F0 -> bus_sel_o=0001, rdata_o=0xFFFFFFF0; sext_i=0 -> 0x000000F0.
REQ-032 Store half addr 0x202, wdata_i=0x0000ABCD -> bus_adr_o=0x200, bus_sel_o=0011, bus_dat_o=0xABCDABCD, bus_we_o=1.
REQ-033 Load word addr 0x101 -> no bus_cyc_o, done_o and err_o pulse together, stall_o released.
REQ-034 flush_i pulsed mid-BUS, ack later -> cycle completes, done_o stays 0, state IDLE.
REQ-035 DBUS_TIMEOUT_EN defined, no ack -> cyc drops after 16 BUS cycles, err_o=1; undefined -> stall_o stays 1.
